// File: rtl/uart_port_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_port_pkg                                                         |
// | Register map codes, STATUS/CTRL field positions and FSM state types. |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package uart_port_pkg;

  localparam logic [1:0] c_ADDR_DATA   = 2'd0;
  localparam logic [1:0] c_ADDR_STATUS = 2'd1;
  localparam logic [1:0] c_ADDR_BAUD   = 2'd2;
  localparam logic [1:0] c_ADDR_CTRL   = 2'd3;

  localparam int c_ST_TX_NFULL  = 0;
  localparam int c_ST_TX_EMPTY  = 1;
  localparam int c_ST_RX_NEMPTY = 2;
  localparam int c_ST_RX_FULL   = 3;
  localparam int c_ST_STICKY_LO = 4;
  localparam int c_ST_LEVEL     = 8;
  localparam int c_ST_TX_BUSY   = 9;
  localparam int c_ST_RX_BUSY   = 10;

  localparam int c_CTRL_STOP2 = 2;
  localparam int c_CTRL_LOOP  = 3;

  localparam logic [1:0] c_PAR_EVEN = 2'b01;
  localparam logic [1:0] c_PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == c_PAR_EVEN) || (mode == c_PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_port_fifo_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fifo_sync                                                             |
// | Synchronous first-word-fall-through FIFO with full/empty/count.      |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = DEPTH[c_AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != c_FULL) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == c_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_port.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_port                                                             |
// | Register-mapped UART: FIFOs, parity, 1/2 stop bits, loopback, irq.   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module uart_port #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int DEFAULT_DIV     = CLOCK_FREQUENCY / (BAUD_RATE * 4),
  parameter int DATA_BITS       = 8,
  parameter int TX_DEPTH        = 16,
  parameter int RX_DEPTH        = 16,
  parameter int RX_THRESH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rd_valid,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  import uart_port_pkg::*;

  localparam int c_TXW = $clog2(TX_DEPTH);
  localparam int c_RXW = $clog2(RX_DEPTH);
  localparam logic [15:0]  c_RESET_DIV = DEFAULT_DIV[15:0];
  localparam logic [2:0]   c_LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [c_RXW:0] c_RX_THRESH = RX_THRESH[c_RXW:0];

  logic [7:0]  r_ctrl;
  logic [15:0] r_baud;
  logic [3:0]  r_sticky;
  logic        w_wr, w_rd, w_cpu_pop;
  logic [15:0] w_status;
  logic [3:0]  w_set, w_clr;

  logic                 w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_ovf;
  logic [DATA_BITS-1:0] w_tx_dout;
  logic [c_TXW:0]       w_tx_count;
  logic                 w_rx_push, w_rx_full, w_rx_empty, w_rx_ovf, w_rx_perr, w_rx_ferr;
  logic [DATA_BITS-1:0] w_rx_dout;
  logic [c_RXW:0]       w_rx_count;

  assign w_wr      = sel && we;
  assign w_rd      = sel && !we;
  assign w_tx_push = w_wr && (addr == c_ADDR_DATA);
  assign w_cpu_pop = w_rd && (addr == c_ADDR_DATA);
  assign w_tx_ovf  = w_tx_push && w_tx_full && !w_tx_pop;
  assign w_rx_ovf  = w_rx_push && w_rx_full && !w_cpu_pop;

  fifo_sync #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(w_tx_push), .din(wdata[DATA_BITS-1:0]), .pop(w_tx_pop),
    .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
  );

  // ---------------- transmitter ----------------
  tx_state_t            r_tx_state;
  logic                 r_tx;
  logic [15:0]          r_tx_div, r_tx_cnt;
  logic [1:0]           r_tx_q;
  logic [2:0]           r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par, r_tx_par_en, r_tx_stop2, r_tx_stop_idx;
  logic                 w_tx_tick, w_tx_bit_end, w_tx_last_stop;

  assign w_tx_tick      = (r_tx_cnt == r_tx_div - 16'd1);
  assign w_tx_bit_end   = w_tx_tick && (r_tx_q == 2'd3);
  assign w_tx_last_stop = (r_tx_state == TX_STOP) && w_tx_bit_end && (!r_tx_stop2 || r_tx_stop_idx);
  // Loading straight out of the last stop bit keeps consecutive frames gap-free
  assign w_tx_pop       = (w_tx_count != '0) && ((r_tx_state == TX_IDLE) || w_tx_last_stop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx <= 1'b1;
      r_tx_div <= c_RESET_DIV;
      r_tx_cnt <= '0;
      r_tx_q <= '0;
      r_tx_idx <= '0;
      r_tx_shift <= '0;
      r_tx_par <= 1'b0;
      r_tx_par_en <= 1'b0;
      r_tx_stop2 <= 1'b0;
      r_tx_stop_idx <= 1'b0;
    end else if (w_tx_pop) begin
      r_tx_state <= TX_START;
      r_tx <= 1'b0;
      r_tx_shift <= w_tx_dout;
      r_tx_div <= r_baud;
      r_tx_cnt <= '0;
      r_tx_q <= '0;
      r_tx_par <= (^w_tx_dout) ^ (r_ctrl[1:0] == c_PAR_ODD);
      r_tx_par_en <= par_enabled(r_ctrl[1:0]);
      r_tx_stop2 <= r_ctrl[c_CTRL_STOP2];
      r_tx_stop_idx <= 1'b0;
    end else if (r_tx_state != TX_IDLE) begin
      r_tx_cnt <= w_tx_tick ? 16'd0 : r_tx_cnt + 16'd1;
      if (w_tx_tick) r_tx_q <= r_tx_q + 2'd1;
      if (w_tx_bit_end) begin
        case (r_tx_state)
          TX_START: begin
            r_tx_state <= TX_DATA;
            r_tx <= r_tx_shift[0];
            r_tx_idx <= '0;
          end
          TX_DATA: begin
            if (r_tx_idx == c_LAST_BIT) begin
              r_tx_state <= r_tx_par_en ? TX_PARITY : TX_STOP;
              r_tx <= r_tx_par_en ? r_tx_par : 1'b1;
            end else begin
              r_tx_idx <= r_tx_idx + 3'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx <= r_tx_shift[1];
            end
          end
          TX_PARITY: begin
            r_tx_state <= TX_STOP;
            r_tx <= 1'b1;
          end
          TX_STOP: begin
            if (r_tx_stop2 && !r_tx_stop_idx) r_tx_stop_idx <= 1'b1;
            else r_tx_state <= TX_IDLE;
          end
          default: r_tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  assign tx = r_tx;

  // ---------------- receiver ----------------
  rx_state_t            r_rx_state;
  logic                 r_rx_s1, r_rx_s2;
  logic [15:0]          r_rx_div, r_rx_cnt;
  logic [1:0]           r_rx_q;
  logic [2:0]           r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_bit, r_rx_par_en, r_rx_par_odd;
  logic                 w_rx_in, w_rx_tick, w_rx_sample, w_rx_bit_end;

  assign w_rx_in      = r_ctrl[c_CTRL_LOOP] ? r_tx : r_rx_s2;
  assign w_rx_tick    = (r_rx_cnt == r_rx_div - 16'd1);
  assign w_rx_sample  = w_rx_tick && (r_rx_q == 2'd1);
  assign w_rx_bit_end = w_rx_tick && (r_rx_q == 2'd3);
  assign w_rx_push    = (r_rx_state == RX_STOP) && w_rx_sample && w_rx_in;
  assign w_rx_ferr    = (r_rx_state == RX_STOP) && w_rx_sample && !w_rx_in;
  assign w_rx_perr    = w_rx_push && r_rx_par_en && (((^r_rx_shift) ^ r_rx_par_bit) != r_rx_par_odd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_div <= c_RESET_DIV;
      r_rx_cnt <= '0;
      r_rx_q <= '0;
      r_rx_idx <= '0;
      r_rx_shift <= '0;
      r_rx_par_bit <= 1'b0;
      r_rx_par_en <= 1'b0;
      r_rx_par_odd <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rx_in) begin
            r_rx_state <= RX_START;
            r_rx_cnt <= '0;
            r_rx_q <= '0;
            r_rx_div <= r_baud;
            r_rx_par_en <= par_enabled(r_ctrl[1:0]);
            r_rx_par_odd <= (r_ctrl[1:0] == c_PAR_ODD);
          end
        end
        RX_WAIT_HIGH: if (w_rx_in) r_rx_state <= RX_IDLE;
        default: begin
          r_rx_cnt <= w_rx_tick ? 16'd0 : r_rx_cnt + 16'd1;
          if (w_rx_tick) r_rx_q <= r_rx_q + 2'd1;
          case (r_rx_state)
            RX_START: begin
              if (w_rx_sample && w_rx_in) r_rx_state <= RX_IDLE;
              else if (w_rx_bit_end) begin
                r_rx_state <= RX_DATA;
                r_rx_idx <= '0;
              end
            end
            RX_DATA: begin
              if (w_rx_sample) r_rx_shift <= {w_rx_in, r_rx_shift[DATA_BITS-1:1]};
              if (w_rx_bit_end) begin
                if (r_rx_idx == c_LAST_BIT) r_rx_state <= r_rx_par_en ? RX_PARITY : RX_STOP;
                else r_rx_idx <= r_rx_idx + 3'd1;
              end
            end
            RX_PARITY: begin
              if (w_rx_sample) r_rx_par_bit <= w_rx_in;
              if (w_rx_bit_end) r_rx_state <= RX_STOP;
            end
            // Resolve at mid first-stop so the next start edge is never missed
            RX_STOP: if (w_rx_sample) r_rx_state <= w_rx_in ? RX_IDLE : RX_WAIT_HIGH;
            default: r_rx_state <= RX_IDLE;
          endcase
        end
      endcase
    end
  end

  fifo_sync #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(w_rx_push), .din(r_rx_shift), .pop(w_cpu_pop),
    .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
  );

  // ---------------- register file ----------------
  always_comb begin
    w_status = '0;
    w_status[c_ST_TX_NFULL]  = !w_tx_full;
    w_status[c_ST_TX_EMPTY]  = w_tx_empty;
    w_status[c_ST_RX_NEMPTY] = !w_rx_empty;
    w_status[c_ST_RX_FULL]   = w_rx_full;
    w_status[c_ST_STICKY_LO +: 4] = r_sticky;
    w_status[c_ST_LEVEL]     = (w_rx_count >= c_RX_THRESH);
    w_status[c_ST_TX_BUSY]   = (r_tx_state != TX_IDLE);
    w_status[c_ST_RX_BUSY]   = (r_rx_state != RX_IDLE);
  end

  assign w_set = {w_tx_ovf, w_rx_ovf, w_rx_perr, w_rx_ferr};
  assign w_clr = (w_wr && (addr == c_ADDR_STATUS)) ? wdata[7:4] : 4'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      rd_valid <= 1'b0;
      r_ctrl <= '0;
      r_baud <= c_RESET_DIV;
      r_sticky <= '0;
      irq <= 1'b0;
    end else begin
      rd_valid <= w_rd;
      if (w_rd) begin
        case (addr)
          c_ADDR_DATA:   rdata <= w_rx_empty ? 16'h0000 : {7'b0, 1'b1, 8'(w_rx_dout)};
          c_ADDR_STATUS: rdata <= w_status;
          c_ADDR_BAUD:   rdata <= r_baud;
          default:       rdata <= {8'h00, r_ctrl};
        endcase
      end
      if (w_wr && (addr == c_ADDR_BAUD)) r_baud <= (wdata == 16'h0000) ? 16'h0001 : wdata;
      if (w_wr && (addr == c_ADDR_CTRL)) r_ctrl <= wdata[7:0];
      r_sticky <= (r_sticky & ~w_clr) | w_set;
      irq <= |(r_ctrl[7:4] & {|r_sticky, w_status[c_ST_LEVEL], w_tx_empty, !w_rx_empty});
    end
  end

endmodule
`default_nettype wire
